// File: rtl/addsub_pkg.sv
// Shared constants for the add/sub result stage: default data width,
// bit positions of the {N,Z,C,V} flag nibble and the buffer occupancy encoding.
package addsub_pkg;

    localparam int ADDSUB_DEFAULT_WIDTH = 32;

    // Flag nibble layout, MSB first: {N, Z, C, V}
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Occupancy of the two-entry result buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational N/Z/C/V flag generation from a raw adder result.
// Overflow uses operand/result sign bits only; for subtraction b_msb_i is the
// sign of the un-inverted B operand, so the "signs differ" rule applies.
module addsub_flag_calc
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    input  logic             sub_i,
    output logic [3:0]       flags_o
);

    logic sum_msb_s;
    logic ovf_s;

    assign sum_msb_s = sum_i[WIDTH-1];

    // Signed overflow: result sign disagrees with A when operand signs make overflow possible
    always_comb begin
        ovf_s = 1'b0;
        if (sub_i) begin
            ovf_s = (a_msb_i != b_msb_i) && (sum_msb_s != a_msb_i);
        end else begin
            ovf_s = (a_msb_i == b_msb_i) && (sum_msb_s != a_msb_i);
        end
    end

    // Assemble the flag nibble
    always_comb begin
        flags_o         = 4'b0000;
        flags_o[FLAG_N] = sum_msb_s;
        flags_o[FLAG_Z] = (sum_i == {WIDTH{1'b0}});
        flags_o[FLAG_C] = cout_i;
        flags_o[FLAG_V] = ovf_s;
    end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered result stage behind an adder: a two-entry in-order buffer that
// stores each result together with flags computed when it is pushed.
// The head entry drives out_result/out_flags directly from registers, so the
// outputs hold the last popped value while the buffer is empty.
// Optional feature: define ADDRES_STICKY_OVF_EN to add ovf_clr/ovf_sticky,
// a sticky record of any popped entry that carried V=1.
module addsub_result_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_DEFAULT_WIDTH
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
`ifdef ADDRES_STICKY_OVF_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf_sticky
`endif
);

    occ_e             count_q, count_d;
    logic [WIDTH-1:0] head_res_q, head_res_d;
    logic [3:0]       head_flg_q, head_flg_d;
    logic [WIDTH-1:0] tail_res_q, tail_res_d;
    logic [3:0]       tail_flg_q, tail_flg_d;
    logic [3:0]       new_flg_s;
    logic             push_s;
    logic             pop_s;

    addsub_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .sum_i   (in_sum),
        .cout_i  (in_cout),
        .a_msb_i (in_a_msb),
        .b_msb_i (in_b_msb),
        .sub_i   (in_sub),
        .flags_o (new_flg_s)
    );

    assign push_s = in_valid  & in_ready;
    assign pop_s  = out_ready & out_valid;

    // Handshake outputs decoded purely from the registered occupancy
    always_comb begin
        in_ready  = (count_q != OCC_FULL);
        out_valid = (count_q != OCC_EMPTY);
    end

    // Buffer next state: head is the oldest entry, tail only used when full
    always_comb begin
        count_d    = count_q;
        head_res_d = head_res_q;
        head_flg_d = head_flg_q;
        tail_res_d = tail_res_q;
        tail_flg_d = tail_flg_q;
        case (count_q)
            OCC_EMPTY: begin
                if (push_s) begin
                    head_res_d = in_sum;
                    head_flg_d = new_flg_s;
                    count_d    = OCC_ONE;
                end else begin
                    count_d    = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (push_s && pop_s) begin
                    head_res_d = in_sum;
                    head_flg_d = new_flg_s;
                    count_d    = OCC_ONE;
                end else if (push_s) begin
                    tail_res_d = in_sum;
                    tail_flg_d = new_flg_s;
                    count_d    = OCC_FULL;
                end else if (pop_s) begin
                    count_d    = OCC_EMPTY;
                end else begin
                    count_d    = OCC_ONE;
                end
            end
            OCC_FULL: begin
                if (pop_s) begin
                    head_res_d = tail_res_q;
                    head_flg_d = tail_flg_q;
                    count_d    = OCC_ONE;
                end else begin
                    count_d    = OCC_FULL;
                end
            end
            default: begin
                count_d = OCC_EMPTY;
            end
        endcase
    end

    // Occupancy and entry storage registers; reset discards everything
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count_q    <= OCC_EMPTY;
            head_res_q <= {WIDTH{1'b0}};
            head_flg_q <= 4'b0000;
            tail_res_q <= {WIDTH{1'b0}};
            tail_flg_q <= 4'b0000;
        end else begin
            count_q    <= count_d;
            head_res_q <= head_res_d;
            head_flg_q <= head_flg_d;
            tail_res_q <= tail_res_d;
            tail_flg_q <= tail_flg_d;
        end
    end

    assign out_result = head_res_q;
    assign out_flags  = head_flg_q;

`ifdef ADDRES_STICKY_OVF_EN
    logic ovf_sticky_q, ovf_sticky_d;

    // Sticky overflow: a V=1 pop wins over a simultaneous clear
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (pop_s && head_flg_q[FLAG_V]) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end else begin
            ovf_sticky_d = ovf_sticky_q;
        end
    end

    // Sticky overflow register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`else
    // Sticky overflow tracking not built in this configuration.
`endif

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage (WIDTH=32). A queue-based reference model
// derives results and flags from the operands with wide integer arithmetic.
// Define ADDRES_STICKY_OVF_EN to also exercise the sticky overflow port.
module tb_addsub_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sum;
    logic        in_cout;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        ovf_clr;
    logic        ovf_sticky;

    logic [31:0] cur_a;
    logic [31:0] cur_b;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } ent_t;

    ent_t mq[$];
    ent_t last_e = '0;
    bit   m_sticky = 1'b0;

    addsub_result_stage #(.WIDTH(32)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
`ifdef ADDRES_STICKY_OVF_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
`endif
    );

`ifndef ADDRES_STICKY_OVF_EN
    assign ovf_sticky = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: true arithmetic on the operands, flags from value ranges
    function automatic ent_t model_entry(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint ua, ub, sa, sb, r, sr;
        ent_t   e;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'({{32{a[31]}}, a});
        sb = longint'({{32{b[31]}}, b});
        r  = sub ? (ua - ub) : (ua + ub);
        sr = sub ? (sa - sb) : (sa + sb);
        e.res    = r[31:0];
        e.flg[3] = e.res[31];
        e.flg[2] = (e.res == 32'd0);
        e.flg[1] = sub ? (ua >= ub) : (r >= 64'sh1_0000_0000);
        e.flg[0] = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive adder outputs as a real adder would produce them
    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] wide;
        cur_a    = a;
        cur_b    = b;
        in_sub   = sub;
        wide     = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, sub};
        in_sum   = wide[31:0];
        in_cout  = wide[32];
        in_a_msb = a[31];
        in_b_msb = b[31];
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model update on each rising edge
    initial begin
        forever begin
            ent_t p;
            bit   push, pop;
            @(posedge clk);
            if (rst) begin
                mq.delete();
                last_e   = '0;
                m_sticky = 1'b0;
            end else begin
                push = in_valid && (mq.size() < 2);
                pop  = out_ready && (mq.size() > 0);
                if (pop) begin
                    p      = mq.pop_front();
                    last_e = p;
                    if (p.flg[0]) m_sticky = 1'b1;
                    else if (ovf_clr) m_sticky = 1'b0;
                end else if (ovf_clr) begin
                    m_sticky = 1'b0;
                end
                if (push) mq.push_back(model_entry(cur_a, cur_b, in_sub));
            end
            started = 1'b1;
        end
    end

    // Per-cycle comparison of DUT against the model
    always @(negedge clk) begin
        if (started) begin
            ent_t s;
            s = (mq.size() > 0) ? mq[0] : last_e;
            chk("out_valid",  {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            chk("in_ready",   {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
            chk("out_result", out_result, s.res);
            chk("out_flags",  {28'd0, out_flags}, {28'd0, s.flg});
`ifdef ADDRES_STICKY_OVF_EN
            chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
`endif
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        set_op(32'd0, 32'd0, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_result",    out_result, 32'd0);
        chk("rst_flags",     {28'd0, out_flags}, 32'd0);

        // 0x7FFFFFFF + 1: N=1 Z=0 C=0 V=1 one cycle later
        set_op(32'h7FFF_FFFF, 32'h1, 1'b0); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk("ovf_add_valid",  {31'd0, out_valid}, 32'd1);
        chk("ovf_add_result", out_result, 32'h8000_0000);
        chk("ovf_add_flags",  {28'd0, out_flags}, 32'h9);
        out_ready = 1'b1;
        cyc(); out_ready = 1'b0;
        chk("hold_valid",  {31'd0, out_valid}, 32'd0);
        chk("hold_result", out_result, 32'h8000_0000);
`ifdef ADDRES_STICKY_OVF_EN
        chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
        set_op(32'h7FFF_FFFF, 32'h1, 1'b0); in_valid = 1'b1;
        cyc(); in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b1;
        cyc(); out_ready = 1'b0;
        chk("sticky_clr_vs_set", {31'd0, ovf_sticky}, 32'd1);
        cyc(); ovf_clr = 1'b0;
        chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
`endif

        // 5 - 5: N=0 Z=1 C=1 V=0
        set_op(32'd5, 32'd5, 1'b1); in_valid = 1'b1;
        cyc(); in_valid = 1'b0;
        chk("sub_zero_result", out_result, 32'd0);
        chk("sub_zero_flags",  {28'd0, out_flags}, 32'h6);
        out_ready = 1'b1;
        cyc(); out_ready = 1'b0;

        // Three back-to-back pushes into a stalled stage: two accepted
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            set_op(32'h100 + k, 32'h10, 1'b0);
            cyc();
            if (k == 2) chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("full_head", out_result, 32'h111);
        out_ready = 1'b1;
        cyc();
        chk("drain_second", out_result, 32'h112);
        cyc();
        out_ready = 1'b0;
        chk("drain_empty",  {31'd0, out_valid}, 32'd0);
        chk("drain_ready",  {31'd0, in_ready},  32'd1);
        chk("drain_hold",   out_result, 32'h112);

        // Streaming at occupancy one
        set_op(32'h1000, 32'd0, 1'b0); in_valid = 1'b1;
        cyc();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            set_op(32'h1000 + i, 32'd0, 1'b0);
            cyc();
            chk("stream_ready",  {31'd0, in_ready},  32'd1);
            chk("stream_valid",  {31'd0, out_valid}, 32'd1);
            chk("stream_result", out_result, 32'h1000 + i);
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // Reset while full, with a push offered in the same cycle
        in_valid = 1'b1;
        set_op(32'h55, 32'h22, 1'b0); cyc();
        set_op(32'h66, 32'h22, 1'b0); cyc();
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_result", out_result, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, b;
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? a : pick();
            set_op(a, b, 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
